// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one shared memory port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin priority; otherwise data always beats inst.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_mem_read,
  input  logic [ADDR_W-1:0]   inst_mem_address,
  output logic [DATA_W-1:0]   inst_mem_rdata,
  output logic                inst_mem_resp,
  input  logic                data_mem_read,
  input  logic                data_mem_write,
  input  logic [ADDR_W-1:0]   data_mem_address,
  input  logic [DATA_W-1:0]   data_mem_wdata,
  input  logic [DATA_W/8-1:0] data_mem_byte_enable,
  output logic [DATA_W-1:0]   data_mem_rdata,
  output logic                data_mem_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_byte_enable,
  input  logic [DATA_W-1:0]   pmem_rdata,
  input  logic                pmem_resp
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;
  logic              lat_write;
  logic              lat_data;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              data_req;
  logic              grant_d;
  logic              grant_i;

  assign data_req = data_mem_read | data_mem_write;

`ifdef MEM_ARB_RR_EN
  // last_grant: 0 = inst served last, 1 = data served last
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && (grant_d || grant_i)) begin
      last_grant <= grant_d;
    end
  end

  assign grant_d = data_req & (~inst_mem_read | ~last_grant);
`else
  assign grant_d = data_req;
`endif

  assign grant_i = inst_mem_read & ~grant_d;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (pmem_resp) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_be       <= '0;
      lat_write    <= 1'b0;
      lat_data     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_d) begin
        // a simultaneous read+write is served as the write
        lat_addr  <= data_mem_address & ALIGN_MASK;
        lat_write <= data_mem_write;
        lat_wdata <= data_mem_write ? data_mem_wdata : '0;
        lat_be    <= data_mem_write ? data_mem_byte_enable : '1;
        lat_data  <= 1'b1;
      end else if (state == IDLE && grant_i) begin
        lat_addr  <= inst_mem_address & ALIGN_MASK;
        lat_write <= 1'b0;
        lat_wdata <= '0;
        lat_be    <= '1;
        lat_data  <= 1'b0;
      end
      if (state == BUSY_I && pmem_resp) begin
        inst_rdata_q <= pmem_rdata;
      end
      if (state == BUSY_D && pmem_resp && !lat_write) begin
        data_rdata_q <= pmem_rdata;
      end
    end
  end

  assign pmem_read        = (state == BUSY_I) | ((state == BUSY_D) & ~lat_write);
  assign pmem_write       = (state == BUSY_D) & lat_write;
  assign pmem_address     = lat_addr;
  assign pmem_wdata       = lat_wdata;
  assign pmem_byte_enable = lat_be;
  assign inst_mem_resp    = (state == RESP) & ~lat_data;
  assign data_mem_resp    = (state == RESP) & lat_data;
  assign inst_mem_rdata   = inst_rdata_q;
  assign data_mem_rdata   = data_rdata_q;

  a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst_n)
    !(data_mem_read && data_mem_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter in the default (fixed data-over-inst) build.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_mem_read;
  logic [31:0] inst_mem_address;
  logic [31:0] inst_mem_rdata;
  logic        inst_mem_resp;
  logic        data_mem_read;
  logic        data_mem_write;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic [3:0]  data_mem_byte_enable;
  logic [31:0] data_mem_rdata;
  logic        data_mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_byte_enable;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .inst_mem_read       (inst_mem_read),
    .inst_mem_address    (inst_mem_address),
    .inst_mem_rdata      (inst_mem_rdata),
    .inst_mem_resp       (inst_mem_resp),
    .data_mem_read       (data_mem_read),
    .data_mem_write      (data_mem_write),
    .data_mem_address    (data_mem_address),
    .data_mem_wdata      (data_mem_wdata),
    .data_mem_byte_enable(data_mem_byte_enable),
    .data_mem_rdata      (data_mem_rdata),
    .data_mem_resp       (data_mem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_byte_enable    (pmem_byte_enable),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  // Inputs applied for one cycle; exp is the output bundle expected in the following cycle.
  typedef struct {
    logic         ir;
    logic [31:0]  ia;
    logic         dr;
    logic         dw;
    logic [31:0]  da;
    logic [31:0]  wd;
    logic [3:0]   be;
    logic         rs;
    logic [31:0]  rd;
    logic [135:0] exp;
  } vec_t;

  vec_t vecs[128];
  int   nv = 0;

  function automatic logic [135:0] mkexp(logic pr, logic pw, logic [31:0] pa, logic [31:0] pwd,
                                         logic [3:0] pbe, logic irs, logic [31:0] ird,
                                         logic drs, logic [31:0] drd);
    return {pr, pw, pa, pwd, pbe, irs, ird, drs, drd};
  endfunction

  task automatic add(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                     logic [31:0] wd, logic [3:0] be, logic rs, logic [31:0] rd,
                     logic pr, logic pw, logic [31:0] pa, logic [31:0] pwd, logic [3:0] pbe,
                     logic irs, logic [31:0] ird, logic drs, logic [31:0] drd);
    vecs[nv].ir  = ir;  vecs[nv].ia = ia;
    vecs[nv].dr  = dr;  vecs[nv].dw = dw;
    vecs[nv].da  = da;  vecs[nv].wd = wd;
    vecs[nv].be  = be;  vecs[nv].rs = rs;
    vecs[nv].rd  = rd;
    vecs[nv].exp = mkexp(pr, pw, pa, pwd, pbe, irs, ird, drs, drd);
    nv++;
  endtask

  task automatic drive(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                       logic [31:0] wd, logic [3:0] be, logic rs, logic [31:0] rd);
    inst_mem_read = ir;  inst_mem_address = ia;
    data_mem_read = dr;  data_mem_write = dw;
    data_mem_address = da;  data_mem_wdata = wd;
    data_mem_byte_enable = be;
    pmem_resp = rs;  pmem_rdata = rd;
  endtask

  task automatic chk(string name, logic [135:0] exp);
    logic [135:0] act;
    act = {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
           inst_mem_resp, inst_mem_rdata, data_mem_resp, data_mem_rdata};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] a, d, prev;

    // Fetch at 0x1006 with a two-cycle-late pmem_resp
    add(1,'h1006,0,0,0,0,0,0,0,            1,0,'h1004,0,'hF,0,0,0,0);
    add(1,'h1006,0,0,0,0,0,0,0,            1,0,'h1004,0,'hF,0,0,0,0);
    add(1,'h1006,0,0,0,0,0,0,0,            1,0,'h1004,0,'hF,0,0,0,0);
    add(1,'h1006,0,0,0,0,0,1,'hDEADBEEF,   0,0,'h1004,0,'hF,1,'hDEADBEEF,0,0);
    add(0,0,0,0,0,0,0,0,0,                 0,0,'h1004,0,'hF,0,'hDEADBEEF,0,0);
    // Simultaneous inst read and data write: write first, store leaves data_mem_rdata alone
    add(1,'h100,0,1,'h200,'h12345678,'h3,0,0,           0,1,'h200,'h12345678,'h3,0,'hDEADBEEF,0,0);
    add(1,'h100,0,1,'h200,'h12345678,'h3,1,'hFFFFFFFF,  0,0,'h200,'h12345678,'h3,0,'hDEADBEEF,1,0);
    add(1,'h100,0,0,0,0,0,0,0,             0,0,'h200,'h12345678,'h3,0,'hDEADBEEF,0,0);
    add(1,'h100,0,0,0,0,0,0,0,             1,0,'h100,0,'hF,0,'hDEADBEEF,0,0);
    add(1,'h100,0,0,0,0,0,1,'hCAFE0001,    0,0,'h100,0,'hF,1,'hCAFE0001,0,0);
    add(0,0,0,0,0,0,0,0,0,                 0,0,'h100,0,'hF,0,'hCAFE0001,0,0);
    // Ten back-to-back loads while a fetch waits: fetch is never granted meanwhile
    for (int i = 0; i < 10; i++) begin
      a    = 32'h1000 + 32'(i * 4);
      d    = 32'hA000_0000 + 32'(i);
      prev = (i == 0) ? 32'h0 : d - 32'd1;
      add(1,'h500,1,0,a,0,0,0,0,           1,0,a,0,'hF,0,'hCAFE0001,0,prev);
      add(1,'h500,1,0,a,0,0,1,d,           0,0,a,0,'hF,0,'hCAFE0001,1,d);
      add(1,'h500,1,0,a,0,0,0,0,           0,0,a,0,'hF,0,'hCAFE0001,0,d);
    end
    add(1,'h500,0,0,0,0,0,0,0,             1,0,'h500,0,'hF,0,'hCAFE0001,0,'hA0000009);
    add(1,'h500,0,0,0,0,0,1,'h5555,        0,0,'h500,0,'hF,1,'h5555,0,'hA0000009);
    add(0,0,0,0,0,0,0,0,0,                 0,0,'h500,0,'hF,0,'h5555,0,'hA0000009);
    // Address changes 0x300 -> 0x400 while busy
    add(0,0,1,0,'h300,0,0,0,0,             1,0,'h300,0,'hF,0,'h5555,0,'hA0000009);
    add(0,0,1,0,'h400,0,0,0,0,             1,0,'h300,0,'hF,0,'h5555,0,'hA0000009);
    add(0,0,1,0,'h400,0,0,1,'h33,          0,0,'h300,0,'hF,0,'h5555,1,'h33);
    add(0,0,1,0,'h400,0,0,0,0,             0,0,'h300,0,'hF,0,'h5555,0,'h33);
    add(0,0,1,0,'h400,0,0,0,0,             1,0,'h400,0,'hF,0,'h5555,0,'h33);
    add(0,0,1,0,'h400,0,0,1,'h44,          0,0,'h400,0,'hF,0,'h5555,1,'h44);
    add(0,0,0,0,0,0,0,0,0,                 0,0,'h400,0,'hF,0,'h5555,0,'h44);
    // pmem_resp held high for three cycles
    add(1,'h600,0,0,0,0,0,0,0,             1,0,'h600,0,'hF,0,'h5555,0,'h44);
    add(1,'h600,0,0,0,0,0,1,'h66,          0,0,'h600,0,'hF,1,'h66,0,'h44);
    add(0,0,0,0,0,0,0,1,'h77,              0,0,'h600,0,'hF,0,'h66,0,'h44);
    add(0,0,0,0,0,0,0,1,'h77,              0,0,'h600,0,'hF,0,'h66,0,'h44);
    add(0,0,0,0,0,0,0,0,0,                 0,0,'h600,0,'hF,0,'h66,0,'h44);

    rst_n = 1'b0;
    drive(0,0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1 chk("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      drive(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da,
            vecs[i].wd, vecs[i].be, vecs[i].rs, vecs[i].rd);
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset while a store is in BUSY_D with its pmem_resp arriving
    drive(0,0,0,1,'h700,'hAABBCCDD,'hC,0,0);
    @(posedge clk);
    #1 chk("rst_busy_d", mkexp(0,1,'h700,'hAABBCCDD,'hC,0,'h66,0,'h44));
    pmem_resp = 1'b1;
    rst_n = 1'b0;
    #1 chk("rst_async", '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk($sformatf("rst_quiet%0d", i), '0);
    end
    drive(0,0,1,0,'h800,0,0,0,0);
    @(posedge clk);
    #1 chk("post_rst_req", mkexp(1,0,'h800,0,'hF,0,0,0,0));
    drive(0,0,1,0,'h800,0,0,1,'h88);
    @(posedge clk);
    #1 chk("post_rst_resp", mkexp(0,0,'h800,0,'hF,0,0,1,'h88));
    drive(0,0,0,0,0,0,0,0,0);
    @(posedge clk);
    #1 chk("post_rst_idle", mkexp(0,0,'h800,0,'hF,0,0,0,'h88));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
